// File: rtl/pipe_if_stage_if.sv
// ---------------------------------------------------------------------------
// pipe_if_stage_if -- instruction-memory fetch bus between the IF stage and
// the instruction memory (or I-cache).
//
//   imem_req   : fetch request, held high while a fetch is outstanding
//   imem_addr  : word address of the fetch, stable while imem_req is high
//   imem_ack   : fetch complete (may come in the same cycle as imem_req)
//   imem_rdata : fetched instruction, valid while imem_ack is high
//
// master = IF stage, slave = memory.
// ---------------------------------------------------------------------------
interface pipe_if_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/pipe_if_stage.sv
// ---------------------------------------------------------------------------
// pipe_if_stage -- instruction fetch stage of a 5-stage pipeline with a
// one-instruction branch delay slot.
//
// Ports
//   clock      : sole clock, rising edge
//   resetn     : asynchronous active-low reset
//   nostall    : ID can accept a new instruction this cycle
//   pcsource   : ID next-PC select (00 seq, 01 bpc, 10 rpc, 11 jpc)
//   bpc/rpc/jpc: branch, register-jump and jump targets from ID
//   imem       : fetch bus (master side)
//   dinst      : IF/ID instruction register (0 on a bubble)
//   dpc4       : IF/ID PC+4 register
//   dvalid     : IF/ID holds a real instruction
//
// The stage is a two-state machine. FETCH keeps a request outstanding at pc.
// If the word returns while ID is stalled it is parked in a one-entry skid
// buffer (sinst/spc4) and the machine sits in HOLD with no request until ID
// frees up. A redirect seen while the delay slot is still in flight is
// remembered in redir_pc/redir_valid and applied when the delay slot lands.
// ---------------------------------------------------------------------------
module pipe_if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic                   nostall,
    input  logic [1:0]             pcsource,
    input  logic [31:0]            bpc,
    input  logic [31:0]            rpc,
    input  logic [31:0]            jpc,
    pipe_if_stage_if.master        imem,
    output logic [31:0]            dinst,
    output logic [31:0]            dpc4,
    output logic                   dvalid
);

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] pc_nxt;
    logic [31:0] target;
    logic [31:0] redir_pc;
    logic        redir_valid;
    logic [31:0] sinst;
    logic [31:0] spc4;
    logic        fetch_req;
    logic        fetch_ack;
    logic        consume;
    logic        redirect;
    logic        advance;

    assign pc_plus4 = pc + 32'd4;

    // The instruction in ID only steers the PC on the cycle it is consumed;
    // otherwise pcsource and the targets are stale and must be ignored.
    assign consume  = dvalid & nostall;
    assign redirect = consume & (pcsource != 2'b00);

    always_comb begin
        target = bpc;
        case (pcsource)
            2'b01:   target = bpc;
            2'b10:   target = rpc;
            2'b11:   target = jpc;
            default: target = bpc;
        endcase
    end

    assign fetch_ack = (state == FETCH) & imem.imem_ack;

    // pc moves only when the word at pc has been handed to ID.
    assign advance = (fetch_ack & nostall) | ((state == HOLD) & nostall);

    // A live redirect wins over a remembered one: a remembered redirect can
    // only exist while the delay slot is in flight, and then dvalid=0 so no
    // live redirect can occur in the same cycle anyway.
    always_comb begin
        pc_nxt = pc_plus4;
        if (redirect)
            pc_nxt = target;
        else if (redir_valid)
            pc_nxt = redir_pc;
    end

    // ---------------------------------------------------------------------
    // FSM
    // ---------------------------------------------------------------------
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)
            state <= FETCH;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        fetch_req = 1'b0;
        case (state)
            FETCH: begin
                fetch_req = 1'b1;
                if (imem.imem_ack && !nostall)
                    state_nxt = HOLD;
            end
            HOLD: begin
                if (nostall)
                    state_nxt = FETCH;
            end
            default: state_nxt = FETCH;
        endcase
    end

    assign imem.imem_req  = fetch_req;
    assign imem.imem_addr = pc;

    // ---------------------------------------------------------------------
    // PC and deferred redirect
    // ---------------------------------------------------------------------
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            pc          <= RESET_PC;
            redir_valid <= 1'b0;
            redir_pc    <= 32'h0;
        end else if (advance) begin
            pc          <= pc_nxt;
            redir_valid <= 1'b0;
        end else if (redirect) begin
            // Branch consumed but its delay slot has not arrived yet: the
            // delay slot still comes from the sequential pc, the target is
            // applied when it lands.
            redir_valid <= 1'b1;
            redir_pc    <= target;
        end
    end

    // ---------------------------------------------------------------------
    // IF/ID register and skid buffer
    // ---------------------------------------------------------------------
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            dinst  <= 32'h0;
            dpc4   <= 32'h0;
            dvalid <= 1'b0;
            sinst  <= 32'h0;
            spc4   <= 32'h0;
        end else if (state == FETCH) begin
            if (imem.imem_ack && nostall) begin
                dinst  <= imem.imem_rdata;
                dpc4   <= pc_plus4;
                dvalid <= 1'b1;
            end else if (imem.imem_ack) begin
                // ID stalled: park the word, IF/ID keeps its contents.
                sinst <= imem.imem_rdata;
                spc4  <= pc_plus4;
            end else if (nostall) begin
                // Nothing fetched yet: hand ID a bubble, dpc4 left as is.
                dinst  <= 32'h0;
                dvalid <= 1'b0;
            end
        end else if (nostall) begin
            dinst  <= sinst;
            dpc4   <= spc4;
            dvalid <= 1'b1;
        end
    end

endmodule
